// File: rtl/if_id_stage_reg.sv
// rtl/if_id_stage_reg.sv - IF/ID pipeline register with stall hold, flush bubble and perf counters
// Captures fetched instruction and PC+PC_INC; Reset > Flush > Stall > Load each cycle.
module if_id_stage_reg #(
   parameter logic [31:0] PC_INC    = 32'd4,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter int          CNT_W     = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [31:0]      PCResult,
   input  logic [31:0]      InstrIn,
   input  logic             Stall,
   input  logic             Flush,
   output logic [31:0]      PCPlus4Out,
   output logic [31:0]      InstrOut,
   output logic             ValidOut,
   output logic             PCHold,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // A flush wins over a stall so the PC is free to take the redirect target.
   assign PCHold = Stall & ~Flush & ~Reset;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         PCPlus4Out <= 32'h0;
         InstrOut   <= NOP_INSTR;
         ValidOut   <= 1'b0;
      end else if (Flush) begin
         PCPlus4Out <= 32'h0;
         InstrOut   <= NOP_INSTR;
         ValidOut   <= 1'b0;
      end else if (!Stall) begin
         PCPlus4Out <= PCResult + PC_INC;
         InstrOut   <= InstrIn;
         ValidOut   <= 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         StallCount <= '0;
         FlushCount <= '0;
      end else if (Flush) begin
         if (FlushCount != CNT_MAX) FlushCount <= FlushCount + 1'b1;
      end else if (Stall) begin
         if (StallCount != CNT_MAX) StallCount <= StallCount + 1'b1;
      end
   end

endmodule

// File: tb/tb_if_id_stage_reg.sv
// tb/tb_if_id_stage_reg.sv - scoreboard bench for if_id_stage_reg
// Expected register state is queued at drive time and compared one edge later.
module tb_if_id_stage_reg;

   logic        Clk = 1'b0;
   logic        Reset, Stall, Flush;
   logic [31:0] PCResult, InstrIn;
   logic [31:0] PCPlus4Out, InstrOut, PCPlus4Out_s, InstrOut_s;
   logic        ValidOut, PCHold, ValidOut_s, PCHold_s;
   logic [15:0] StallCount, FlushCount;
   logic [3:0]  StallCount_s, FlushCount_s;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
      int          sc;
      int          fc;
      int          sc4;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [31:0] m_pc, m_instr;
   logic        m_valid;
   int          m_sc, m_fc, m_sc4;

   always #5 Clk = ~Clk;

   if_id_stage_reg dut (
      .Clk(Clk), .Reset(Reset), .PCResult(PCResult), .InstrIn(InstrIn),
      .Stall(Stall), .Flush(Flush), .PCPlus4Out(PCPlus4Out), .InstrOut(InstrOut),
      .ValidOut(ValidOut), .PCHold(PCHold), .StallCount(StallCount), .FlushCount(FlushCount)
   );

   if_id_stage_reg #(.CNT_W(4)) u_small (
      .Clk(Clk), .Reset(Reset), .PCResult(PCResult), .InstrIn(InstrIn),
      .Stall(Stall), .Flush(Flush), .PCPlus4Out(PCPlus4Out_s), .InstrOut(InstrOut_s),
      .ValidOut(ValidOut_s), .PCHold(PCHold_s), .StallCount(StallCount_s), .FlushCount(FlushCount_s)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic rst, input logic [31:0] pc, input logic [31:0] instr,
                       input logic stl, input logic fl);
      exp_t e;
      @(negedge Clk);
      Reset = rst; PCResult = pc; InstrIn = instr; Stall = stl; Flush = fl;
      #1;
      check("pchold", {63'd0, PCHold}, {63'd0, stl & ~fl & ~rst});
      if (rst) begin
         m_pc = 0; m_instr = 0; m_valid = 0; m_sc = 0; m_fc = 0; m_sc4 = 0;
      end else if (fl) begin
         m_pc = 0; m_instr = 0; m_valid = 0;
         if (m_fc < 65535) m_fc++;
      end else if (stl) begin
         if (m_sc < 65535) m_sc++;
         if (m_sc4 < 15) m_sc4++;
      end else begin
         m_pc = pc + 32'd4; m_instr = instr; m_valid = 1;
      end
      e.pc = m_pc; e.instr = m_instr; e.valid = m_valid;
      e.sc = m_sc; e.fc = m_fc; e.sc4 = m_sc4;
      q.push_back(e);
      @(posedge Clk);
      #1;
      e = q.pop_front();
      check("pcplus4", {32'd0, PCPlus4Out}, {32'd0, e.pc});
      check("instr",   {32'd0, InstrOut},   {32'd0, e.instr});
      check("valid",   {63'd0, ValidOut},   {63'd0, e.valid});
      check("stallcnt", {48'd0, StallCount}, 64'(e.sc));
      check("flushcnt", {48'd0, FlushCount}, 64'(e.fc));
      check("stallcnt4", {60'd0, StallCount_s}, 64'(e.sc4));
   endtask

   initial begin
      Reset = 1; Stall = 0; Flush = 0; PCResult = 0; InstrIn = 0;
      m_pc = 0; m_instr = 0; m_valid = 0; m_sc = 0; m_fc = 0; m_sc4 = 0;

      step(1, 32'h0, 32'h0, 0, 0);
      step(1, 32'h0, 32'h0, 1, 0);
      step(0, 32'h0000_0010, 32'h8C22_0004, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 32'h100 + 32'(i * 4), 32'hDEAD_0000 + 32'(i), 1, 0);
      step(0, 32'h0000_0200, 32'h1234_5678, 1, 1);
      step(0, 32'hFFFF_FFFC, 32'hAAAA_5555, 0, 0);
      step(0, 32'h0000_0040, 32'h2001_0001, 0, 1);
      for (int i = 0; i < 20; i++) step(0, 32'($urandom), 32'($urandom), 1, 0);
      step(0, 32'h0000_0300, 32'h0C00_0010, 0, 0);
      step(0, 32'h0000_0304, 32'h1111_2222, 1, 0);
      step(1, 32'h0000_0308, 32'h3333_4444, 1, 0);
      step(0, 32'h0000_0400, 32'h8C22_0004, 0, 0);
      for (int i = 0; i < 30; i++)
         step(($urandom_range(0, 15) == 0), 32'($urandom) & 32'hFFFF_FFFC, 32'($urandom),
              $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
